// File: rtl/fila_andares.sv
// fila_andares: circular FIFO of floor codes, first-word fall-through head.
// Optional FILA_DEDUP_EN refuses a push whose floor is already queued.
module fila_andares #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       clear_n,
  input  logic                       enable,
  input  logic                       push,
  input  logic [WIDTH-1:0]           D,
  input  logic                       pop,
  output logic [WIDTH-1:0]           Q,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       rejeitado,
  output logic                       erro_pop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             dup;
  logic             acc_push;
  logic             acc_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign Q     = empty ? '0 : mem[rd_ptr];

`ifdef FILA_DEDUP_EN
  logic [AW-1:0] idx;

  // Scan only the live window starting at the head.
  always_comb begin
    dup = 1'b0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if ((CW'(i) < count) && (mem[idx] == D))
        dup = 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign acc_push = enable & push & ~full & ~dup;
  assign acc_pop  = enable & pop & ~empty;

  always_ff @(posedge clock) begin
    if (acc_push)
      mem[wr_ptr] <= D;
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      rejeitado <= 1'b0;
      erro_pop  <= 1'b0;
    end else begin
      if (acc_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (acc_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count     <= count + CW'(acc_push) - CW'(acc_pop);
      rejeitado <= enable & push & ~acc_push;
      erro_pop  <= enable & pop & empty;
    end
  end

endmodule

// File: tb/tb_fila_andares.sv
// tb_fila_andares: directed vectors for fila_andares (DEPTH 8, WIDTH 4).
// Dedup expectations follow FILA_DEDUP_EN.
module tb_fila_andares;

  logic       clock = 1'b0;
  logic       clear_n;
  logic       enable;
  logic       push;
  logic [3:0] D;
  logic       pop;
  logic [3:0] Q;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       rejeitado;
  logic       erro_pop;

  int n_chk  = 0;
  int n_fail = 0;

  fila_andares #(.WIDTH(4), .DEPTH(8)) dut (
    .clock(clock),
    .clear_n(clear_n),
    .enable(enable),
    .push(push),
    .D(D),
    .pop(pop),
    .Q(Q),
    .empty(empty),
    .full(full),
    .count(count),
    .rejeitado(rejeitado),
    .erro_pop(erro_pop)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    push = 1'b0;
    pop  = 1'b0;
  endtask

  initial begin
    clear_n = 1'b0;
    enable  = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    D       = '0;
    step();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_q", Q, 0);
    chk("rst_rej", rejeitado, 0);
    chk("rst_erro", erro_pop, 0);
    clear_n = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      push = 1'b1;
      D    = 4'(i);
      step();
      chk("fill_count", count, i);
      chk("fill_q", Q, 1);
    end
    chk("fill_full", full, 1);
    D = 4'd9;
    step();
    chk("ovf_rej", rejeitado, 1);
    chk("ovf_count", count, 8);
    push = 1'b0;
    step();
    chk("ovf_rej_drop", rejeitado, 0);

    pop = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_q", Q, i);
      step();
      chk("drain_erro", erro_pop, 0);
    end
    pop = 1'b0;
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    for (int i = 0; i < 20; i++) begin
      push = 1'b1;
      D    = 4'd3;
      step();
      chk("wrap_q", Q, 3);
      push = 1'b0;
      pop  = 1'b1;
      step();
      pop  = 1'b0;
    end
    chk("wrap_empty", empty, 1);
    for (int i = 5; i <= 7; i++) begin
      push = 1'b1;
      D    = 4'(i);
      step();
    end
    push = 1'b0;
    chk("wrap_q5", Q, 5);
    chk("wrap_count", count, 3);
    pop = 1'b1;
    for (int i = 5; i <= 7; i++) begin
      chk("wrap_order", Q, i);
      step();
    end
    pop = 1'b0;
    chk("wrap_done", empty, 1);

    push = 1'b1;
    pop  = 1'b1;
    D    = 4'd4;
    step();
    chk("se_count", count, 1);
    chk("se_q", Q, 4);
    chk("se_erro", erro_pop, 1);
    chk("se_rej", rejeitado, 0);
    idle();
    step();
    chk("se_erro_drop", erro_pop, 0);

    push = 1'b1;
    for (int i = 0; i < 7; i++) begin
      D = 4'(8 + i);
      step();
    end
    chk("sf_full", full, 1);
    pop = 1'b1;
    D   = 4'd15;
    step();
    chk("sf_count", count, 7);
    chk("sf_rej", rejeitado, 1);
    chk("sf_q", Q, 8);
    push = 1'b0;
    for (int i = 0; i < 4; i++)
      step();
    pop = 1'b0;
    chk("sm_pre", count, 3);
    chk("sm_pre_q", Q, 12);
    push = 1'b1;
    pop  = 1'b1;
    D    = 4'd2;
    step();
    chk("sm_count", count, 3);
    chk("sm_q", Q, 13);
    push = 1'b0;
    for (int i = 0; i < 3; i++)
      step();
    pop = 1'b0;
    chk("sm_empty", empty, 1);

    push = 1'b1;
    D    = 4'd2;
    step();
    D = 4'd5;
    step();
    chk("dd_two", count, 2);
    step();
    push = 1'b0;
`ifdef FILA_DEDUP_EN
    chk("dd_rej", rejeitado, 1);
    chk("dd_count", count, 2);
`else
    chk("dd_rej", rejeitado, 0);
    chk("dd_count", count, 3);
`endif
    pop = 1'b1;
    step();
    chk("dd_head", Q, 5);
    push = 1'b1;
    D    = 4'd5;
    step();
    idle();
`ifdef FILA_DEDUP_EN
    chk("dd_pp_rej", rejeitado, 1);
    chk("dd_pp_count", count, 0);
`else
    chk("dd_pp_rej", rejeitado, 0);
    chk("dd_pp_count", count, 2);
`endif

    clear_n = 1'b0;
    step();
    clear_n = 1'b1;
    push    = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      D = 4'(i);
      step();
    end
    chk("mr_pre", count, 5);
    clear_n = 1'b0;
    D       = 4'd9;
    step();
    chk("mr_count", count, 0);
    chk("mr_empty", empty, 1);
    chk("mr_q", Q, 0);
    clear_n = 1'b1;
    D       = 4'd3;
    step();
    D = 4'd4;
    step();
    push = 1'b0;
    chk("en_pre", count, 2);

    enable = 1'b0;
    push   = 1'b1;
    pop    = 1'b1;
    D      = 4'd6;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_count", count, 2);
      chk("en_q", Q, 3);
      chk("en_rej", rejeitado, 0);
      chk("en_erro", erro_pop, 0);
    end
    enable = 1'b1;
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
